// File: rtl/chip8_fb_pkg.sv
// -----------------------------------------------------------------------------
// chip8_fb_pkg
// Shared constants and types for the CHIP-8 framebuffer controller:
// screen geometry, command field widths, the controller state enum and the
// registered draw-command record.
// -----------------------------------------------------------------------------
package chip8_fb_pkg;

    localparam int FB_COLS = 64;
    localparam int FB_ROWS = 32;

    localparam int X_W     = 6;   // column origin, already modulo FB_COLS
    localparam int Y_W     = 5;   // row origin, already modulo FB_ROWS
    localparam int N_W     = 4;   // sprite row count
    localparam int ADDR_W  = 12;  // sprite memory address
    localparam int BYTE_W  = 8;   // one sprite row
    localparam int ROW_W   = 5;   // framebuffer row index / row counter

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FETCH = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } fb_state_e;

    typedef struct packed {
        logic [X_W-1:0]    x;
        logic [Y_W-1:0]    y;
        logic [N_W-1:0]    n;
        logic [ADDR_W-1:0] addr;
    } draw_cmd_t;

    // Unwrapped target row: bit ROW_W set means the row fell off the bottom.
    function automatic logic [ROW_W:0] row_sum(input logic [Y_W-1:0] y,
                                               input logic [ROW_W-1:0] k);
        return {1'b0, y} + {1'b0, k};
    endfunction

endpackage

// File: rtl/chip8_fb_ctrl_if.sv
// -----------------------------------------------------------------------------
// chip8_fb_ctrl_if
// Bundles the command handshake, the sprite memory read port and the
// framebuffer row port of chip8_fb_ctrl.
//   slave  : controller view (commands and read data in, strobes out)
//   master : environment view (commands and read data out, strobes in)
// -----------------------------------------------------------------------------
interface chip8_fb_ctrl_if;
    import chip8_fb_pkg::*;

    // command handshake
    logic              draw_req;
    logic [X_W-1:0]    draw_x;
    logic [Y_W-1:0]    draw_y;
    logic [N_W-1:0]    draw_n;
    logic [ADDR_W-1:0] draw_addr;
    logic              clear_req;
    logic              busy;
    logic              done;
    logic              collision;

    // sprite memory read port (data one cycle after mem_rd)
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [BYTE_W-1:0] mem_rdata;

    // framebuffer row port (read data one cycle after fb_rd)
    logic               fb_rd;
    logic               fb_we;
    logic [ROW_W-1:0]   fb_row;
    logic [FB_COLS-1:0] fb_wdata;
    logic [FB_COLS-1:0] fb_rdata;

    modport slave (
        input  draw_req, draw_x, draw_y, draw_n, draw_addr, clear_req,
        input  mem_rdata, fb_rdata,
        output busy, done, collision,
        output mem_rd, mem_addr,
        output fb_rd, fb_we, fb_row, fb_wdata
    );

    modport master (
        output draw_req, draw_x, draw_y, draw_n, draw_addr, clear_req,
        output mem_rdata, fb_rdata,
        input  busy, done, collision,
        input  mem_rd, mem_addr,
        input  fb_rd, fb_we, fb_row, fb_wdata
    );

endinterface

// File: rtl/chip8_fb_ctrl_sprite_mask.sv
// -----------------------------------------------------------------------------
// chip8_sprite_mask
// Combinational expansion of one sprite byte into a 64-bit row mask.
// Byte bit 7-i lands on column x+i. With WRAP=0 columns past 63 are
// dropped; with WRAP=1 they wrap modulo 64.
//   sprite_byte : sprite row from memory
//   x           : column origin
//   mask        : bit c set = pixel in column c toggles
// -----------------------------------------------------------------------------
module chip8_sprite_mask
    import chip8_fb_pkg::*;
#(
    parameter bit WRAP = 1'b0
) (
    input  logic [BYTE_W-1:0]  sprite_byte,
    input  logic [X_W-1:0]     x,
    output logic [FB_COLS-1:0] mask
);

    always_comb begin : mask_gen
        logic [X_W:0] col;
        mask = '0;
        col  = '0;
        for (int i = 0; i < BYTE_W; i++) begin
            // one extra bit so an off-screen column is visible as col[X_W]
            col = {1'b0, x} + (X_W+1)'(i);
            if (sprite_byte[3'(BYTE_W - 1 - i)] && (WRAP || !col[X_W])) begin
                mask[col[X_W-1:0]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/chip8_fb_ctrl.sv
// -----------------------------------------------------------------------------
// chip8_fb_ctrl
// Framebuffer command engine for a CHIP-8 display: clears the 64x32 screen
// or XOR-draws an n-row sprite from sprite memory, reporting pixel collision.
//   clk50 : system clock, all logic on posedge
//   reset : synchronous active-high reset
//   bus   : command handshake, sprite memory port and framebuffer row port
//   WRAP  : 0 = clip at right/bottom edge, 1 = wrap around the screen
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for clear_req / draw_req
// CLEAR | writing zero to row row_q, one row per cycle
// FETCH | reading sprite byte k and framebuffer row (y+k)
// WRITE | writing framebuffer row (y+k) XOR sprite mask
// DONE  | one-cycle done pulse, collision valid
// -----------------------------------------------------------------------------
module chip8_fb_ctrl
    import chip8_fb_pkg::*;
#(
    parameter bit WRAP = 1'b0
) (
    input  logic           clk50,
    input  logic           reset,
    chip8_fb_ctrl_if.slave bus
);

    fb_state_e        state_q, state_d;
    draw_cmd_t        cmd_q, cmd_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             collision_q, collision_d;

    logic [ROW_W:0]     tgt_row;
    logic               row_on_screen;
    logic               last_row;
    logic [FB_COLS-1:0] mask;
    logic [FB_COLS-1:0] overlap;

    logic               busy_c;
    logic               done_c;
    logic               mem_rd_c;
    logic [ADDR_W-1:0]  mem_addr_c;
    logic               fb_rd_c;
    logic               fb_we_c;
    logic [ROW_W-1:0]   fb_row_c;
    logic [FB_COLS-1:0] fb_wdata_c;

    chip8_sprite_mask #(
        .WRAP (WRAP)
    ) u_sprite_mask (
        .sprite_byte (bus.mem_rdata),
        .x           (cmd_q.x),
        .mask        (mask)
    );

    assign tgt_row       = row_sum(cmd_q.y, row_q);
    // Rows below the screen still go through FETCH/WRITE so timing stays
    // fixed; only the write strobe is suppressed.
    assign row_on_screen = WRAP || !tgt_row[ROW_W];
    assign last_row      = (row_q == ({1'b0, cmd_q.n} - 5'd1));
    assign overlap       = bus.fb_rdata & mask;

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        row_d       = row_q;
        collision_d = collision_q;

        busy_c      = 1'b0;
        done_c      = 1'b0;
        mem_rd_c    = 1'b0;
        mem_addr_c  = '0;
        fb_rd_c     = 1'b0;
        fb_we_c     = 1'b0;
        fb_row_c    = '0;
        fb_wdata_c  = '0;

        case (state_q)
            IDLE: begin
                // clear has priority; a simultaneous draw is dropped
                if (bus.clear_req) begin
                    row_d       = '0;
                    collision_d = 1'b0;
                    state_d     = CLEAR;
                end else if (bus.draw_req) begin
                    cmd_d.x     = bus.draw_x;
                    cmd_d.y     = bus.draw_y;
                    cmd_d.n     = bus.draw_n;
                    cmd_d.addr  = bus.draw_addr;
                    row_d       = '0;
                    collision_d = 1'b0;
                    state_d     = (bus.draw_n == '0) ? DONE : FETCH;
                end
            end

            CLEAR: begin
                busy_c     = 1'b1;
                fb_we_c    = 1'b1;
                fb_row_c   = row_q;
                fb_wdata_c = '0;
                if (row_q == 5'(FB_ROWS - 1)) begin
                    state_d = DONE;
                end else begin
                    row_d = row_q + 5'd1;
                end
            end

            FETCH: begin
                busy_c     = 1'b1;
                mem_rd_c   = 1'b1;
                mem_addr_c = cmd_q.addr + ADDR_W'(row_q);
                fb_rd_c    = 1'b1;
                fb_row_c   = tgt_row[ROW_W-1:0];
                state_d    = WRITE;
            end

            WRITE: begin
                busy_c   = 1'b1;
                fb_row_c = tgt_row[ROW_W-1:0];
                if (row_on_screen) begin
                    fb_we_c     = 1'b1;
                    fb_wdata_c  = bus.fb_rdata ^ mask;
                    collision_d = collision_q | (|overlap);
                end
                if (last_row) begin
                    state_d = DONE;
                end else begin
                    row_d   = row_q + 5'd1;
                    state_d = FETCH;
                end
            end

            DONE: begin
                done_c  = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk50) begin
        if (reset) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            row_q       <= '0;
            collision_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            row_q       <= row_d;
            collision_q <= collision_d;
        end
    end

    assign bus.busy      = busy_c;
    assign bus.done      = done_c;
    assign bus.collision = collision_q;
    assign bus.mem_rd    = mem_rd_c;
    assign bus.mem_addr  = mem_addr_c;
    assign bus.fb_rd     = fb_rd_c;
    assign bus.fb_we     = fb_we_c;
    assign bus.fb_row    = fb_row_c;
    assign bus.fb_wdata  = fb_wdata_c;

endmodule

// File: tb/tb_chip8_fb_ctrl.sv
// -----------------------------------------------------------------------------
// tb_chip8_fb_ctrl
// Directed bench for chip8_fb_ctrl. Two instances (clip and wrap) run the
// same command stream against their own framebuffer models and a shared
// sprite memory model.
// -----------------------------------------------------------------------------
module tb_chip8_fb_ctrl;
    import chip8_fb_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    chip8_fb_ctrl_if bus0 ();
    chip8_fb_ctrl_if bus1 ();

    chip8_fb_ctrl #(.WRAP(1'b0)) dut0 (.clk50(clk), .reset(reset), .bus(bus0.slave));
    chip8_fb_ctrl #(.WRAP(1'b1)) dut1 (.clk50(clk), .reset(reset), .bus(bus1.slave));

    logic [7:0]  mem [4096];
    logic [63:0] fb0 [32];
    logic [63:0] fb1 [32];

    int n_cmp = 0;
    int n_bad = 0;
    int we0 = 0, we1 = 0, done0 = 0, memrd0 = 0, conflict = 0;

    // memory / framebuffer models: read data valid the cycle after the strobe
    always @(posedge clk) begin
        if (bus0.mem_rd) bus0.mem_rdata <= mem[bus0.mem_addr];
        if (bus1.mem_rd) bus1.mem_rdata <= mem[bus1.mem_addr];
        if (bus0.fb_rd)  bus0.fb_rdata  <= fb0[bus0.fb_row];
        if (bus1.fb_rd)  bus1.fb_rdata  <= fb1[bus1.fb_row];
        if (bus0.fb_we)  fb0[bus0.fb_row] <= bus0.fb_wdata;
        if (bus1.fb_we)  fb1[bus1.fb_row] <= bus1.fb_wdata;
        if (bus0.fb_we)  we0++;
        if (bus1.fb_we)  we1++;
        if (bus0.done)   done0++;
        if (bus0.mem_rd) memrd0++;
        if ((bus0.fb_rd && bus0.fb_we) || (bus1.fb_rd && bus1.fb_we)) conflict++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want tests complete");
        $fatal(1, "time limit");
    end

    function automatic logic [4:0] st0();
        return {bus0.busy, bus0.done, bus0.mem_rd, bus0.fb_rd, bus0.fb_we};
    endfunction

    function automatic logic [4:0] st1();
        return {bus1.busy, bus1.done, bus1.mem_rd, bus1.fb_rd, bus1.fb_we};
    endfunction

    task automatic set_cmd(input logic clr, input logic drw, input logic [5:0] x,
                           input logic [4:0] y, input logic [3:0] n, input logic [11:0] a);
        bus0.clear_req = clr; bus1.clear_req = clr;
        bus0.draw_req  = drw; bus1.draw_req  = drw;
        bus0.draw_x    = x;   bus1.draw_x    = x;
        bus0.draw_y    = y;   bus1.draw_y    = y;
        bus0.draw_n    = n;   bus1.draw_n    = n;
        bus0.draw_addr = a;   bus1.draw_addr = a;
    endtask

    task automatic idle_cmd();
        set_cmd(1'b0, 1'b0, 6'd0, 5'd0, 4'd0, 12'd0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_cmd();
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({st0(), st1(), bus0.collision, bus1.collision} !== 12'd0) begin
            n_bad++;
            $display("FAIL reset_ctrl: status %b/%b coll %b/%b, want all 0",
                     st0(), st1(), bus0.collision, bus1.collision);
        end
        n_cmp++;
        if (bus0.fb_row !== 5'd0 || bus0.fb_wdata !== 64'd0 || bus0.mem_addr !== 12'd0) begin
            n_bad++;
            $display("FAIL reset_bus: row %0d wdata %h addr %h, want 0 0 0",
                     bus0.fb_row, bus0.fb_wdata, bus0.mem_addr);
        end
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (st0() !== 5'd0) begin
            n_bad++;
            $display("FAIL reset_idle: status %b, want 00000", st0());
        end
    endtask

    task automatic test_clear();
        int we_snap;
        we_snap = we0;
        set_cmd(1'b1, 1'b0, 6'd0, 5'd0, 4'd0, 12'd0);
        @(negedge clk);
        idle_cmd();
        for (int c = 1; c <= 32; c++) begin
            n_cmp++;
            if (st0() !== 5'b10001 || st1() !== 5'b10001 ||
                bus0.fb_row !== 5'(c - 1) || bus1.fb_row !== 5'(c - 1) ||
                bus0.fb_wdata !== 64'd0 || bus1.fb_wdata !== 64'd0) begin
                n_bad++;
                $display("FAIL clear_t%0d: status %b/%b row %0d data %h, want 10001 row %0d data 0",
                         c, st0(), st1(), bus0.fb_row, bus0.fb_wdata, c - 1);
            end
            @(negedge clk);
        end
        n_cmp++;
        if (st0() !== 5'b01000 || st1() !== 5'b01000 || bus0.collision !== 1'b0) begin
            n_bad++;
            $display("FAIL clear_done: status %b/%b coll %b, want 01000 coll 0",
                     st0(), st1(), bus0.collision);
        end
        @(negedge clk);
        n_cmp++;
        if (st0() !== 5'd0 || (we0 - we_snap) !== 32) begin
            n_bad++;
            $display("FAIL clear_count: status %b writes %0d, want 00000 writes 32",
                     st0(), we0 - we_snap);
        end
    endtask

    // x=0 y=0 n=1 byte 0xF0: columns 0..3; second call erases it
    task automatic test_draw(input logic [63:0] exp_wdata, input logic exp_coll, input string tag);
        set_cmd(1'b0, 1'b1, 6'd0, 5'd0, 4'd1, 12'h200);
        @(negedge clk);
        idle_cmd();
        n_cmp++;
        if (st0() !== 5'b10110 || st1() !== 5'b10110 || bus0.mem_addr !== 12'h200 || bus0.fb_row !== 5'd0) begin
            n_bad++;
            $display("FAIL %s_fetch: status %b/%b addr %h row %0d, want 10110 addr 200 row 0",
                     tag, st0(), st1(), bus0.mem_addr, bus0.fb_row);
        end
        @(negedge clk);
        n_cmp++;
        if (st0() !== 5'b10001 || bus0.fb_row !== 5'd0 || bus0.fb_wdata !== exp_wdata ||
            bus1.fb_wdata !== exp_wdata) begin
            n_bad++;
            $display("FAIL %s_write: status %b row %0d data %h/%h, want 10001 row 0 data %h",
                     tag, st0(), bus0.fb_row, bus0.fb_wdata, bus1.fb_wdata, exp_wdata);
        end
        @(negedge clk);
        n_cmp++;
        if (st0() !== 5'b01000 || bus0.collision !== exp_coll || bus1.collision !== exp_coll) begin
            n_bad++;
            $display("FAIL %s_done: status %b coll %b/%b, want 01000 coll %b",
                     tag, st0(), bus0.collision, bus1.collision, exp_coll);
        end
        @(negedge clk);
        n_cmp++;
        if (st0() !== 5'd0 || fb0[0] !== exp_wdata) begin
            n_bad++;
            $display("FAIL %s_fb: status %b fb row0 %h, want 00000 row0 %h",
                     tag, st0(), fb0[0], exp_wdata);
        end
    endtask

    task automatic test_n_zero();
        int we_snap, rd_snap;
        we_snap = we0;
        rd_snap = memrd0;
        set_cmd(1'b0, 1'b1, 6'd3, 5'd4, 4'd0, 12'h200);
        @(negedge clk);
        idle_cmd();
        n_cmp++;
        if (st0() !== 5'b01000 || bus0.collision !== 1'b0) begin
            n_bad++;
            $display("FAIL nzero_done: status %b coll %b, want 01000 coll 0", st0(), bus0.collision);
        end
        @(negedge clk);
        n_cmp++;
        if (st0() !== 5'd0 || we0 !== we_snap || memrd0 !== rd_snap) begin
            n_bad++;
            $display("FAIL nzero_access: status %b writes %0d reads %0d, want 00000 0 0",
                     st0(), we0 - we_snap, memrd0 - rd_snap);
        end
    endtask

    task automatic test_edge();
        set_cmd(1'b0, 1'b1, 6'd60, 5'd31, 4'd2, 12'h300);
        @(negedge clk);
        idle_cmd();
        n_cmp++;
        if (st0() !== 5'b10110 || st1() !== 5'b10110 || bus0.fb_row !== 5'd31 || bus0.mem_addr !== 12'h300) begin
            n_bad++;
            $display("FAIL edge_fetch0: status %b/%b row %0d addr %h, want 10110 row 31 addr 300",
                     st0(), st1(), bus0.fb_row, bus0.mem_addr);
        end
        @(negedge clk);
        n_cmp++;
        if (st0() !== 5'b10001 || bus0.fb_row !== 5'd31 || bus0.fb_wdata !== 64'hF000_0000_0000_0000) begin
            n_bad++;
            $display("FAIL edge_clip_w31: status %b row %0d data %h, want 10001 row 31 data f000000000000000",
                     st0(), bus0.fb_row, bus0.fb_wdata);
        end
        n_cmp++;
        if (st1() !== 5'b10001 || bus1.fb_row !== 5'd31 || bus1.fb_wdata !== 64'hF000_0000_0000_000F) begin
            n_bad++;
            $display("FAIL edge_wrap_w31: status %b row %0d data %h, want 10001 row 31 data f00000000000000f",
                     st1(), bus1.fb_row, bus1.fb_wdata);
        end
        @(negedge clk);
        n_cmp++;
        if (st0() !== 5'b10110 || bus0.fb_row !== 5'd0 || bus0.mem_addr !== 12'h301) begin
            n_bad++;
            $display("FAIL edge_fetch1: status %b row %0d addr %h, want 10110 row 0 addr 301",
                     st0(), bus0.fb_row, bus0.mem_addr);
        end
        @(negedge clk);
        n_cmp++;
        if (st0() !== 5'b10000) begin
            n_bad++;
            $display("FAIL edge_clip_skip: status %b, want 10000", st0());
        end
        n_cmp++;
        if (st1() !== 5'b10001 || bus1.fb_row !== 5'd0 || bus1.fb_wdata !== 64'hF000_0000_0000_000F) begin
            n_bad++;
            $display("FAIL edge_wrap_w0: status %b row %0d data %h, want 10001 row 0 data f00000000000000f",
                     st1(), bus1.fb_row, bus1.fb_wdata);
        end
        @(negedge clk);
        n_cmp++;
        if (st0() !== 5'b01000 || st1() !== 5'b01000 || bus0.collision !== 1'b0 || bus1.collision !== 1'b0) begin
            n_bad++;
            $display("FAIL edge_done: status %b/%b coll %b/%b, want 01000 coll 0",
                     st0(), st1(), bus0.collision, bus1.collision);
        end
        @(negedge clk);
        n_cmp++;
        if (fb0[0] !== 64'd0 || fb0[31] !== 64'hF000_0000_0000_0000 ||
            fb1[0] !== 64'hF000_0000_0000_000F || fb1[31] !== 64'hF000_0000_0000_000F) begin
            n_bad++;
            $display("FAIL edge_fb: clip %h/%h wrap %h/%h, want 0/f000000000000000 f00000000000000f/f00000000000000f",
                     fb0[0], fb0[31], fb1[0], fb1[31]);
        end
    endtask

    task automatic test_clear_wins();
        int we_snap, rd_snap;
        we_snap = we0;
        rd_snap = memrd0;
        set_cmd(1'b1, 1'b1, 6'd8, 5'd2, 4'd3, 12'h300);
        @(negedge clk);
        idle_cmd();
        for (int c = 1; c <= 32; c++) begin
            n_cmp++;
            if (st0() !== 5'b10001 || st1() !== 5'b10001 || bus0.fb_row !== 5'(c - 1)) begin
                n_bad++;
                $display("FAIL arb_t%0d: status %b/%b row %0d, want 10001 row %0d",
                         c, st0(), st1(), bus0.fb_row, c - 1);
            end
            @(negedge clk);
        end
        n_cmp++;
        if (st0() !== 5'b01000) begin
            n_bad++;
            $display("FAIL arb_done: status %b, want 01000", st0());
        end
        @(negedge clk);
        n_cmp++;
        if (memrd0 !== rd_snap || (we0 - we_snap) !== 32 || fb1[31] !== 64'd0) begin
            n_bad++;
            $display("FAIL arb_access: reads %0d writes %0d wrap row31 %h, want 0 32 0",
                     memrd0 - rd_snap, we0 - we_snap, fb1[31]);
        end
    endtask

    task automatic test_busy_ignore();
        int we_snap, rd_snap;
        we_snap = we0;
        rd_snap = memrd0;
        set_cmd(1'b0, 1'b1, 6'd8, 5'd2, 4'd1, 12'h200);
        @(negedge clk);
        set_cmd(1'b1, 1'b1, 6'd0, 5'd5, 4'd4, 12'h300);
        n_cmp++;
        if (st0() !== 5'b10110 || bus0.mem_addr !== 12'h200 || bus0.fb_row !== 5'd2) begin
            n_bad++;
            $display("FAIL busy_fetch: status %b addr %h row %0d, want 10110 addr 200 row 2",
                     st0(), bus0.mem_addr, bus0.fb_row);
        end
        @(negedge clk);
        n_cmp++;
        if (st0() !== 5'b10001 || bus0.fb_row !== 5'd2 || bus0.fb_wdata !== 64'h0000_0000_0000_0F00) begin
            n_bad++;
            $display("FAIL busy_write: status %b row %0d data %h, want 10001 row 2 data f00",
                     st0(), bus0.fb_row, bus0.fb_wdata);
        end
        @(negedge clk);
        n_cmp++;
        if (st0() !== 5'b01000) begin
            n_bad++;
            $display("FAIL busy_done: status %b, want 01000", st0());
        end
        @(negedge clk);
        n_cmp++;
        if (st0() !== 5'd0) begin
            n_bad++;
            $display("FAIL busy_req_in_done: status %b, want 00000", st0());
        end
        idle_cmd();
        @(negedge clk);
        n_cmp++;
        if (st0() !== 5'd0 || (we0 - we_snap) !== 1 || (memrd0 - rd_snap) !== 1) begin
            n_bad++;
            $display("FAIL busy_count: status %b writes %0d reads %0d, want 00000 1 1",
                     st0(), we0 - we_snap, memrd0 - rd_snap);
        end
    endtask

    task automatic test_reset_mid();
        int  we_snap, done_snap;
        bit  bad;
        set_cmd(1'b0, 1'b1, 6'd4, 5'd10, 4'd5, 12'h400);
        @(negedge clk);
        idle_cmd();
        @(negedge clk);
        n_cmp++;
        if (st0() !== 5'b10001 || bus0.fb_row !== 5'd10 || bus0.fb_wdata !== 64'h0000_0000_0000_0810) begin
            n_bad++;
            $display("FAIL rstmid_write: status %b row %0d data %h, want 10001 row 10 data 810",
                     st0(), bus0.fb_row, bus0.fb_wdata);
        end
        @(negedge clk);
        n_cmp++;
        if (st0() !== 5'b10110 || bus0.fb_row !== 5'd11 || bus0.mem_addr !== 12'h401) begin
            n_bad++;
            $display("FAIL rstmid_fetch1: status %b row %0d addr %h, want 10110 row 11 addr 401",
                     st0(), bus0.fb_row, bus0.mem_addr);
        end
        reset = 1'b1;
        we_snap   = we0;
        done_snap = done0;
        @(negedge clk);
        n_cmp++;
        if (st0() !== 5'd0 || st1() !== 5'd0 || bus0.fb_wdata !== 64'd0 || bus0.mem_addr !== 12'd0) begin
            n_bad++;
            $display("FAIL rstmid_abort: status %b/%b data %h addr %h, want 00000 0 0",
                     st0(), st1(), bus0.fb_wdata, bus0.mem_addr);
        end
        @(negedge clk);
        reset = 1'b0;
        bad = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (st0() !== 5'd0 || st1() !== 5'd0) bad = 1'b1;
        end
        n_cmp++;
        if (bad || we0 !== we_snap || done0 !== done_snap) begin
            n_bad++;
            $display("FAIL rstmid_quiet: activity %b writes %0d dones %0d, want 0 0 0",
                     bad, we0 - we_snap, done0 - done_snap);
        end
        set_cmd(1'b1, 1'b0, 6'd0, 5'd0, 4'd0, 12'd0);
        @(negedge clk);
        idle_cmd();
        n_cmp++;
        if (st0() !== 5'b10001 || bus0.fb_row !== 5'd0) begin
            n_bad++;
            $display("FAIL rstmid_clear_start: status %b row %0d, want 10001 row 0", st0(), bus0.fb_row);
        end
        repeat (32) @(negedge clk);
        n_cmp++;
        if (st0() !== 5'b01000 || bus0.collision !== 1'b0) begin
            n_bad++;
            $display("FAIL rstmid_clear_done: status %b coll %b, want 01000 coll 0", st0(), bus0.collision);
        end
        @(negedge clk);
        n_cmp++;
        if (fb0[10] !== 64'd0 || fb0[2] !== 64'd0 || fb1[0] !== 64'd0) begin
            n_bad++;
            $display("FAIL rstmid_fb: rows %h %h %h, want all 0", fb0[10], fb0[2], fb1[0]);
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        mem[12'h200] = 8'hF0;
        mem[12'h300] = 8'hFF;
        mem[12'h301] = 8'hFF;
        mem[12'h400] = 8'h81;
        mem[12'h401] = 8'h42;
        mem[12'h402] = 8'h24;
        mem[12'h403] = 8'h18;
        mem[12'h404] = 8'hFF;

        test_reset();
        test_clear();
        test_draw(64'h0000_0000_0000_000F, 1'b0, "draw");
        test_draw(64'h0000_0000_0000_0000, 1'b1, "redraw");
        test_n_zero();
        test_edge();
        test_clear_wins();
        test_busy_ignore();
        test_reset_mid();

        n_cmp++;
        if (conflict !== 0) begin
            n_bad++;
            $display("FAIL rd_we_overlap: %0d cycles with fb_rd and fb_we, want 0", conflict);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
